// File: rtl/cc_deserializer.sv
`timescale 1ns/1ps
// Wrapped-burst line assembler: collects BEATS x DATA_W beats starting at the critical word
// and pushes {offset, line} into the fill FIFO.
module cc_deserializer #(
   parameter int DATA_W = 64,
   parameter int BEATS  = 8,
   parameter int OFS_W  = 6
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid_i,
   input  logic [OFS_W-1:0]                  req_offset_i,
   output logic                              req_ready_o,
   input  logic [DATA_W-1:0]                 rdata_i,
   input  logic                              rlast_i,
   input  logic                              rvalid_i,
   output logic                              rready_o,
   input  logic                              fifo_full_i,
   output logic                              fifo_wren_o,
   output logic [OFS_W+DATA_W*BEATS-1:0]     fifo_wdata_o,
   output logic                              err_o
);

   // state   | meaning
   // IDLE    | waiting for a fill request, req_ready_o high
   // COLLECT | accepting beats into wrapped slots, rready_o high
   // WRITE   | line complete, push when the fill FIFO has room

   localparam int CNT_W  = $clog2(BEATS);
   localparam int LINE_W = DATA_W * BEATS;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [OFS_W-1:0]    r_ofs;
   logic [LINE_W-1:0]   r_line;
   logic                r_err;
   logic                r_req_ready;
   logic                r_rready;

   logic [CNT_W-1:0]    w_slot;
   logic                w_last;

   // Upper offset bits select the critical word; the low byte bits ride along unused.
   assign w_slot = r_ofs[OFS_W-1 -: CNT_W] + r_cnt;
   assign w_last = (r_cnt == CNT_W'(BEATS-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ofs       <= '0;
         r_line      <= '0;
         r_err       <= 1'b0;
         r_req_ready <= 1'b1;
         r_rready    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_ofs       <= req_offset_i;
                  r_cnt       <= '0;
                  r_state     <= S_COLLECT;
                  r_req_ready <= 1'b0;
                  r_rready    <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (rvalid_i) begin
                  for (int k = 0; k < BEATS; k++) begin
                     if (w_slot == CNT_W'(k))
                        r_line[(BEATS-1-k)*DATA_W +: DATA_W] <= rdata_i;
                  end
                  // Burst length is fixed by the counter; rlast only flags protocol errors.
                  if (rlast_i != w_last)
                     r_err <= 1'b1;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_state  <= S_WRITE;
                     r_rready <= 1'b0;
                  end
               end
            end
            S_WRITE: begin
               if (!fifo_full_i) begin
                  r_state     <= S_IDLE;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_rready    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o  = r_req_ready;
   assign rready_o     = r_rready;
   assign fifo_wren_o  = (r_state == S_WRITE) & ~fifo_full_i;
   assign fifo_wdata_o = {r_ofs, r_line};
   assign err_o        = r_err;

endmodule

// File: tb/tb_cc_deserializer.sv
`timescale 1ns/1ps
// Bench for cc_deserializer: directed bursts, a transaction-level line model checked every
// cycle, and literal expectations for the hand-computed cases.
module tb_cc_deserializer;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [5:0]    req_offset;
   logic          req_ready;
   logic [63:0]   rdata;
   logic          rlast;
   logic          rvalid;
   logic          rready;
   logic          fifo_full;
   logic          fifo_wren;
   logic [517:0]  fifo_wdata;
   logic          err;

   always #5 clk = ~clk;

   cc_deserializer dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_offset_i (req_offset),
      .req_ready_o  (req_ready),
      .rdata_i      (rdata),
      .rlast_i      (rlast),
      .rvalid_i     (rvalid),
      .rready_o     (rready),
      .fifo_full_i  (fifo_full),
      .fifo_wren_o  (fifo_wren),
      .fifo_wdata_o (fifo_wdata),
      .err_o        (err)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [517:0] act, input logic [517:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   // Model: phase 0 waiting for request, 1 gathering beats, 2 line complete.
   int          m_phase = 0;
   int          m_n = 0;
   logic [5:0]  m_ofs = '0;
   logic [63:0] m_w [8];
   bit          m_err = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_n = 0; m_ofs = '0; m_err = 1'b0;
         for (int k = 0; k < 8; k++) m_w[k] = '0;
      end else begin
         case (m_phase)
            0: if (req_valid) begin m_ofs = req_offset; m_n = 0; m_phase = 1; end
            1: if (rvalid) begin
                  m_w[(int'(m_ofs) / 8 + m_n) % 8] = rdata;
                  if (rlast != (m_n == 7)) m_err = 1'b1;
                  m_n++;
                  if (m_n == 8) m_phase = 2;
               end
            default: if (!fifo_full) m_phase = 0;
         endcase
      end
   end

   int           push_cnt = 0;
   int           rr_cycles = 0;
   logic [517:0] last_push = '0;

   always @(negedge clk) begin
      logic [517:0] exp_data;
      exp_data[517:512] = m_ofs;
      for (int k = 0; k < 8; k++) exp_data[511-64*k -: 64] = m_w[k];
      chk("req_ready", req_ready, m_phase == 0);
      chk("rready",    rready,    m_phase == 1);
      chk("wren",      fifo_wren, (m_phase == 2) && !fifo_full);
      chk("err",       err,       m_err);
      chk("wdata",     fifo_wdata, exp_data);
      if (fifo_wren) begin push_cnt++; last_push = fifo_wdata; end
      if (rready) rr_cycles++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic req(input logic [5:0] ofs);
      req_valid = 1'b1; req_offset = ofs;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic send(input logic [63:0] base, input bit toggle, input int lastpos, input int nb);
      for (int i = 0; i < nb; i++) begin
         rvalid = 1'b1; rdata = base + 64'(i); rlast = (i == lastpos);
         tick();
         if (toggle) begin rvalid = 1'b0; rlast = 1'b0; tick(); end
      end
      rvalid = 1'b0; rlast = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_offset = '0; rdata = '0;
      rlast = 1'b0; rvalid = 1'b0; fifo_full = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_wdata", fifo_wdata, '0);

      // Aligned burst, back-to-back
      rr_cycles = 0;
      req(6'h00);
      send(64'hD0D0_0000_0000_0000, 1'b0, 7, 8);
      repeat (3) tick();
      chk("t1_pushes", push_cnt, 1);
      chk("t1_rr_cycles", rr_cycles, 8);
      chk("t1_line", last_push, {6'h00,
          64'hD0D0_0000_0000_0000, 64'hD0D0_0000_0000_0001,
          64'hD0D0_0000_0000_0002, 64'hD0D0_0000_0000_0003,
          64'hD0D0_0000_0000_0004, 64'hD0D0_0000_0000_0005,
          64'hD0D0_0000_0000_0006, 64'hD0D0_0000_0000_0007});
      chk("t1_err", err, 0);

      // Wrapped burst from word 5
      req(6'h28);
      send(64'hB0B0_0000_0000_0000, 1'b0, 7, 8);
      repeat (3) tick();
      chk("t2_pushes", push_cnt, 2);
      chk("t2_ofs",   last_push[517:512], 6'h28);
      chk("t2_slot5", last_push[191:128], 64'hB0B0_0000_0000_0000);
      chk("t2_slot7", last_push[63:0],    64'hB0B0_0000_0000_0002);
      chk("t2_slot0", last_push[511:448], 64'hB0B0_0000_0000_0003);
      chk("t2_slot4", last_push[255:192], 64'hB0B0_0000_0000_0007);

      // rvalid toggling every cycle
      rr_cycles = 0;
      req(6'h10);
      send(64'h3333_0000_0000_0000, 1'b1, 7, 8);
      repeat (3) tick();
      chk("t3_pushes", push_cnt, 3);
      chk("t3_rr_cycles", rr_cycles, 15);
      chk("t3_slot2", last_push[383:320], 64'h3333_0000_0000_0000);

      // FIFO full for 5 cycles after the 8th beat
      fifo_full = 1'b1;
      req(6'h08);
      send(64'h4444_0000_0000_0000, 1'b0, 7, 8);
      repeat (5) tick();
      chk("t4_held", push_cnt, 3);
      fifo_full = 1'b0;
      repeat (3) tick();
      chk("t4_pushes", push_cnt, 4);
      chk("t4_slot1", last_push[447:384], 64'h4444_0000_0000_0000);

      // Early rlast on beat 4
      req(6'h00);
      send(64'h5555_0000_0000_0000, 1'b0, 3, 8);
      repeat (3) tick();
      chk("t5_err", err, 1);
      chk("t5_pushes", push_cnt, 5);

      // Reset after beat 3, then a clean burst
      req(6'h18);
      send(64'h6666_0000_0000_0000, 1'b0, 7, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rready", rready, 0);
      chk("t6_req_ready", req_ready, 1);
      chk("t6_err", err, 0);
      repeat (3) tick();
      chk("t6_no_push", push_cnt, 5);
      req(6'h3F);
      send(64'h7777_0000_0000_0000, 1'b0, 7, 8);
      repeat (3) tick();
      chk("t6_pushes", push_cnt, 6);
      chk("t6_ofs", last_push[517:512], 6'h3F);
      chk("t6_slot7", last_push[63:0], 64'h7777_0000_0000_0000);
      chk("t6_slot6", last_push[127:64], 64'h7777_0000_0000_0007);
      chk("t6_err_clean", err, 0);

      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
